// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch (I) and memory (D) stages.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests; default is fixed D priority.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic        d_dump,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  output logic        m_dump,
  input  logic [15:0] m_rdata,
  input  logic        m_done,
  input  logic        m_stall,
  input  logic        m_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic d_req, granted, expire, finish, pick_d, gnt_i, gnt_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
`endif

  assign d_req   = d_rd | d_wr;
  assign granted = (state_q != IDLE);
  assign expire  = granted && (wdog_q == WDOG_LAST);
  assign finish  = granted && (m_done || expire);

  // Tie-break: a write wins over a read when both D strobes are set
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    pick_d  = d_req;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
    if (d_req && i_rd) pick_d = ~last_d_q;
`endif
    case (state_q)
      IDLE: begin
        wdog_d = 8'd0;
        if (pick_d) begin
          state_d = GNT_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = d_wr;
          rd_d    = d_rd & ~d_wr;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (i_rd) begin
          state_d = GNT_I;
          addr_d  = i_addr;
          wdata_d = 16'd0;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      GNT_I, GNT_D: begin
        if (finish) begin
          state_d = IDLE;
          wdog_d  = 8'd0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wdog_q   <= 8'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // Responses are masked while reset is asserted so an aborted grant never pulses done
  assign gnt_i = rst_n && (state_q == GNT_I);
  assign gnt_d = rst_n && (state_q == GNT_D);

  assign i_done  = gnt_i & (m_done | expire);
  assign i_err   = gnt_i & ((m_err & m_done) | (expire & ~m_done));
  assign i_rdata = gnt_i ? m_rdata : 16'd0;
  assign d_done  = gnt_d & (m_done | expire);
  assign d_err   = gnt_d & ((m_err & m_done) | (expire & ~m_done));
  assign d_rdata = gnt_d ? m_rdata : 16'd0;

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_rd    = rd_q;
  assign m_wr    = wr_q;
  assign m_dump  = gnt_d & d_dump;
  assign busy    = granted;

endmodule
